pipeline_debug_ctrl: RTL and testbench
======================================

# pipeline_debug_ctrl

Run/step/halt sequencer for the 5-stage MIPS pipeline. It gates instruction fetch and the pipeline-wide stage enable, drains in-flight instructions on halt, and, while halted, takes over the REGMEM read port to stream all registers out over a valid/ready channel. It sits between the host command interface (UART debug unit) and the IF/ID/EX/MEM/WB stage enables.

## Interface
- NREGS, 32, number of registers dumped
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after fetch stops (IF/ID..MEM/WB depth)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 DUMP
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- halt_detected  in  1  HALT instruction retiring in WB this cycle
- if_enable  out  1  PC / IF-ID write enable
- pipe_enable  out  1  enable for ID/EX, EX/MEM, MEM/WB registers and REGMEM writes
- regfile_dbg_sel  out  1  REGMEM rs port driven by regfile_dbg_addr instead of IF/ID rs
- regfile_dbg_addr  out  ADDR_W  debug read address
- regfile_dbg_data  in  DATA_W  REGMEM data_1 (asynchronous read)
- dump_valid  out  1  dump word valid
- dump_data  out  DATA_W  dump word, equals regfile_dbg_data (combinational pass-through)
- dump_last  out  1  marks register NREGS-1
- dump_ready  in  1  consumer accepts dump word
- status_halted  out  1  FSM in HALTED
- cycle_count  out  32  pipe_enable-active cycle count

## Operation
- Moore FSM. States: HALTED (reset state), RUN, STEP, DRAIN, DUMP. All outputs decode from registered state/counters.
- HALTED: if_enable=0, pipe_enable=0, cmd_ready=1, status_halted=1. RUN→RUN, STEP→STEP, DUMP→DUMP (idx←0), HALT→stay.
- RUN: if_enable=1, pipe_enable=1, cmd_ready=1. HALT cmd→DRAIN. halt_detected→HALTED directly, so instructions behind HALT never write back. halt_detected wins over a same-cycle HALT cmd. RUN/STEP/DUMP cmds are accepted and discarded.
- STEP: exactly one cycle with if_enable=1, pipe_enable=1, cmd_ready=0, then DRAIN. If halt_detected→HALTED.
- DRAIN: if_enable=0, pipe_enable=1, cmd_ready=0. Drain counter loads DRAIN_CYCLES-1 on entry and →HALTED when it reaches 0. If halt_detected→HALTED immediately.
- DUMP: if_enable=0, pipe_enable=0, cmd_ready=0, regfile_dbg_sel=1, regfile_dbg_addr=idx, dump_valid=1, dump_last=(idx==NREGS-1). On dump_valid&&dump_ready: idx+1. Handshake on last→HALTED. Holds indefinitely while dump_ready=0, with data stable.
- idx width is ADDR_W. No wrap beyond NREGS-1.
- Reset value of every output: if_enable 0, pipe_enable 0, cmd_ready 1, regfile_dbg_sel 0, regfile_dbg_addr 0, dump_valid 0, dump_last 0, status_halted 1, cycle_count 0. Reset mid-operation (any state, mid-dump) returns to HALTED, and the dump is abandoned.

## Timing
- Command accepted at edge N: the new state's outputs are valid in cycle N+1. Latency is 1 cycle.
- STEP: if_enable high for exactly 1 cycle, pipe_enable high for 1+DRAIN_CYCLES consecutive cycles, status_halted returns on the following cycle.
- HALT from RUN: if_enable drops the cycle after acceptance, and pipe_enable drops DRAIN_CYCLES cycles later.
- halt_detected in cycle N: both enables are 0 in cycle N+1.
- Dump: NREGS handshakes minimum. With dump_ready tied 1, this is NREGS consecutive cycles.
- cycle_count increments at each edge where pipe_enable=1, and wraps modulo 2^32.

## Configuration
- PIPE_DEBUG_CYCLE_COUNT_EN defined: the 32-bit cycle counter is implemented as above.
- Undefined: there is no counter register, and cycle_count is tied to 0.

## Test plan
- Reset low for 2 cycles, then release → HALTED, all outputs at reset values, cmd_ready=1.
- STEP with DRAIN_CYCLES=4 → if_enable high 1 cycle, pipe_enable high exactly 5 cycles, status_halted=1 after; with the count feature compiled in, cycle_count=5.
- RUN, then HALT cmd 10 cycles later → if_enable drops next cycle, pipe_enable drops 4 cycles after that. Same-cycle halt_detected → both 0 next cycle.
- Preload r1=AAAABBBB, r2=12345678, then DUMP with dump_ready toggling 1/0 → 32 words in order, word 1=AAAABBBB, word 2=12345678, dump_last only on word 31, data stable while stalled.
- Reset asserted at dump index 7 → HALTED next cycle, dump_valid=0, regfile_dbg_sel=0. A new DUMP restarts at index 0.
- DUMP cmd issued in RUN → accepted (cmd_ready=1) and ignored: dump_valid stays 0 and the FSM stays in RUN.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// Run/step/halt/dump sequencer for the 5-stage pipeline: gates fetch and stage enables,
// drains on halt, and streams the register file out while halted. Optional: PIPE_DEBUG_CYCLE_COUNT_EN.
module pipeline_debug_ctrl #(
    parameter int NREGS        = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    input  logic              halt_detected,
    output logic              if_enable,
    output logic              pipe_enable,
    output logic              regfile_dbg_sel,
    output logic [ADDR_W-1:0] regfile_dbg_addr,
    input  logic [DATA_W-1:0] regfile_dbg_data,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic              status_halted,
    output logic [31:0]       cycle_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_TOP = CNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DUMP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cmd_fire;
    logic              dump_fire;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign dump_fire = dump_valid && dump_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HALTED;
            drain_cnt_q <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: state_d = S_STEP;
                        OP_DUMP: state_d = S_DUMP;
                        default: state_d = S_HALTED;
                    endcase
                end
            end
            // A retiring HALT instruction beats a same-cycle host HALT so nothing behind it writes back.
            S_RUN: begin
                if (halt_detected)                        state_d = S_HALTED;
                else if (cmd_fire && cmd_op == OP_HALT)   state_d = S_DRAIN;
            end
            S_STEP:  state_d = halt_detected ? S_HALTED : S_DRAIN;
            S_DRAIN: begin
                if (halt_detected || drain_cnt_q == '0)   state_d = S_HALTED;
            end
            S_DUMP: begin
                if (dump_fire && idx_q == LAST_IDX)       state_d = S_HALTED;
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (state_d == S_DRAIN && state_q != S_DRAIN)
            drain_cnt_d = DRAIN_TOP;
        else if (state_q == S_DRAIN && drain_cnt_q != '0)
            drain_cnt_d = drain_cnt_q - 1'b1;
    end

    // Index stops at the last register; the final handshake leaves DUMP instead of wrapping.
    always_comb begin
        idx_d = idx_q;
        if (state_q == S_HALTED && cmd_fire && cmd_op == OP_DUMP)
            idx_d = '0;
        else if (state_q == S_DUMP && dump_fire && idx_q != LAST_IDX)
            idx_d = idx_q + 1'b1;
    end

    always_comb begin
        if_enable        = 1'b0;
        pipe_enable      = 1'b0;
        cmd_ready        = 1'b0;
        regfile_dbg_sel  = 1'b0;
        regfile_dbg_addr = '0;
        dump_valid       = 1'b0;
        dump_last        = 1'b0;
        status_halted    = 1'b0;
        case (state_q)
            S_HALTED: begin
                cmd_ready     = 1'b1;
                status_halted = 1'b1;
            end
            S_RUN: begin
                if_enable   = 1'b1;
                pipe_enable = 1'b1;
                cmd_ready   = 1'b1;
            end
            S_STEP: begin
                if_enable   = 1'b1;
                pipe_enable = 1'b1;
            end
            S_DRAIN: pipe_enable = 1'b1;
            S_DUMP: begin
                regfile_dbg_sel  = 1'b1;
                regfile_dbg_addr = idx_q;
                dump_valid       = 1'b1;
                dump_last        = (idx_q == LAST_IDX);
            end
            default: begin
                cmd_ready     = 1'b1;
                status_halted = 1'b1;
            end
        endcase
    end

    assign dump_data = regfile_dbg_data;

`ifdef PIPE_DEBUG_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (pipe_enable)
            cycle_count_d = cycle_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cycle_count_q <= '0;
        else        cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: reset, step, run/halt, halt_detected, dump, reset mid-dump.
module tb_pipeline_debug_ctrl;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic              cmd_ready;
    logic              halt_detected;
    logic              if_enable;
    logic              pipe_enable;
    logic              regfile_dbg_sel;
    logic [ADDR_W-1:0] regfile_dbg_addr;
    logic [DATA_W-1:0] regfile_dbg_data;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_ready;
    logic              status_halted;
    logic [31:0]       cycle_count;

    logic [DATA_W-1:0] regs [NREGS];
    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign regfile_dbg_data = regs[regfile_dbg_addr];

    pipeline_debug_ctrl #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .halt_detected(halt_detected), .if_enable(if_enable), .pipe_enable(pipe_enable),
        .regfile_dbg_sel(regfile_dbg_sel), .regfile_dbg_addr(regfile_dbg_addr),
        .regfile_dbg_data(regfile_dbg_data), .dump_valid(dump_valid), .dump_data(dump_data),
        .dump_last(dump_last), .dump_ready(dump_ready), .status_halted(status_halted),
        .cycle_count(cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".if_en"},   if_enable,        0);
        chk({tag, ".pipe_en"}, pipe_enable,      0);
        chk({tag, ".ready"},   cmd_ready,        1);
        chk({tag, ".sel"},     regfile_dbg_sel,  0);
        chk({tag, ".addr"},    regfile_dbg_addr, 0);
        chk({tag, ".dvalid"},  dump_valid,       0);
        chk({tag, ".dlast"},   dump_last,        0);
        chk({tag, ".halted"},  status_halted,    1);
    endtask

    initial begin
        int if_cnt, pipe_cnt, w, cyc;
        logic [DATA_W-1:0] held;
        logic              stalled;
        logic [31:0]       exp_cc;

        for (int i = 0; i < NREGS; i++) regs[i] = 32'hC0DE_0000 + i;
        regs[1] = 32'hAAAA_BBBB;
        regs[2] = 32'h1234_5678;

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; halt_detected = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        chk_reset_outputs("in_reset");
        chk("in_reset.cc", cycle_count, 0);
        reset = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // STEP: 1 fetch cycle, 5 enable cycles, then halted
        send(2'b10);
        chk("step.ready", cmd_ready, 0);
        if_cnt = 0; pipe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (if_enable) if_cnt++;
            if (pipe_enable) pipe_cnt++;
            if (i == 4) chk("step.pipe_last", pipe_enable, 1);
            if (i == 5) chk("step.halted_after", status_halted, 1);
            tick();
        end
        chk("step.if_cycles", if_cnt, 1);
        chk("step.pipe_cycles", pipe_cnt, 5);
`ifdef PIPE_DEBUG_CYCLE_COUNT_EN
        exp_cc = 32'd5;
`else
        exp_cc = 32'd0;
`endif
        chk("step.cycle_count", cycle_count, exp_cc);

        // RUN then HALT after 10 cycles
        send(2'b01);
        chk("run.if_en", if_enable, 1);
        chk("run.pipe_en", pipe_enable, 1);
        chk("run.halted", status_halted, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("run.ready_for_halt", cmd_ready, 1);
        send(2'b00);
        chk("drain.if_en", if_enable, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain.pipe_en%0d", i), pipe_enable, 1);
            chk($sformatf("drain.ready%0d", i), cmd_ready, 0);
            tick();
        end
        chk("drain.pipe_off", pipe_enable, 0);
        chk("drain.halted", status_halted, 1);
`ifdef PIPE_DEBUG_CYCLE_COUNT_EN
        exp_cc = 32'd20;
`endif
        chk("run.cycle_count", cycle_count, exp_cc);

        // halt_detected wins over same-cycle HALT command
        send(2'b01);
        tick();
        halt_detected = 1'b1;
        send(2'b00);
        halt_detected = 1'b0;
        chk("hdet.if_en", if_enable, 0);
        chk("hdet.pipe_en", pipe_enable, 0);
        chk("hdet.halted", status_halted, 1);

        // DUMP while running is accepted and ignored
        send(2'b01);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        chk("rundump.ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("rundump.dvalid", dump_valid, 0);
        chk("rundump.if_en", if_enable, 1);
        chk("rundump.sel", regfile_dbg_sel, 0);
        halt_detected = 1'b1;
        tick();
        halt_detected = 1'b0;
        chk("rundump.halted", status_halted, 1);

        // DUMP with toggling ready
        send(2'b11);
        chk("dump.sel", regfile_dbg_sel, 1);
        chk("dump.pipe_en", pipe_enable, 0);
        w = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (w < NREGS && cyc < 200) begin
            dump_ready = cyc[0];
            if (stalled) chk($sformatf("dump.stable%0d", w), dump_data, held);
            chk($sformatf("dump.valid%0d", w), dump_valid, 1);
            chk($sformatf("dump.data%0d", w), dump_data, regs[w]);
            chk($sformatf("dump.last%0d", w), dump_last, (w == NREGS - 1) ? 1 : 0);
            if (w == 1) chk("dump.word1", dump_data, 32'hAAAA_BBBB);
            if (w == 2) chk("dump.word2", dump_data, 32'h1234_5678);
            stalled = !dump_ready;
            held    = dump_data;
            if (dump_ready) w++;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump.words", w, NREGS);
        chk("dump.done_halted", status_halted, 1);
        chk("dump.done_valid", dump_valid, 0);

        // Reset at index 7 abandons the dump; a new dump restarts at 0
        dump_ready = 1'b1;
        send(2'b11);
        for (int i = 0; i < 7; i++) tick();
        chk("rst7.addr", regfile_dbg_addr, 7);
        chk("rst7.data", dump_data, regs[7]);
        reset = 1'b0;
        tick();
        chk_reset_outputs("rst7");
        reset = 1'b1;
        dump_ready = 1'b0;
        send(2'b11);
        chk("redump.addr", regfile_dbg_addr, 0);
        chk("redump.valid", dump_valid, 1);
        chk("redump.data", dump_data, regs[0]);
        tick();
        chk("redump.hold_addr", regfile_dbg_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
